// File: rtl/alu_mdu_seq.sv
// alu_mdu_seq: handshaked EX-stage execute unit.
//   Single-cycle integer ALU, MUL_CYCLES-latency multiplier and a radix-2
//   restoring divider. Shifts are masked to log2(XLEN) bits. Divide-by-zero
//   and signed overflow return the RISC-V defined results in one cycle.
//
// Ports:
//   clk, rst              clock (rising edge), async active-high reset
//   flush                 drop in-flight op and any held result
//   in_valid / in_ready   request handshake (in_ready only in IDLE)
//   A, B, ALUOp           operands and opcode, latched on accept
//   out_valid / out_ready result handshake, result held until taken
//   ALUOut, Eq, Gt, GtU   result and compare flags of the accepted operands
//   busy                  multi-cycle op in progress
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a request, in_ready=1
// MUL   | multiply latency countdown
// DIV   | one quotient bit per cycle, XLEN cycles
// DONE  | result and flags held on the outputs until out_ready
//
// Opcodes: ADD=0 SUB=1 SLT=2 SLTU=3 AND=4 OR=5 XOR=6 SLL=7 SRL=8 SRA=9
//          MUL=10 MULH=11 MULHSU=12 MULHU=13 DIV=14 DIVU=15 REM=16 REMU=17

module alu_mdu_seq #(
   parameter int XLEN       = 32,
   parameter int MUL_CYCLES = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] A,
   input  logic [XLEN-1:0] B,
   input  logic [4:0]      ALUOp,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] ALUOut,
   output logic            Eq,
   output logic            Gt,
   output logic            GtU,
   output logic            busy
);

   localparam logic [4:0] OP_ADD    = 5'd0;
   localparam logic [4:0] OP_SUB    = 5'd1;
   localparam logic [4:0] OP_SLT    = 5'd2;
   localparam logic [4:0] OP_SLTU   = 5'd3;
   localparam logic [4:0] OP_AND    = 5'd4;
   localparam logic [4:0] OP_OR     = 5'd5;
   localparam logic [4:0] OP_XOR    = 5'd6;
   localparam logic [4:0] OP_SLL    = 5'd7;
   localparam logic [4:0] OP_SRL    = 5'd8;
   localparam logic [4:0] OP_SRA    = 5'd9;
   localparam logic [4:0] OP_MUL    = 5'd10;
   localparam logic [4:0] OP_MULH   = 5'd11;
   localparam logic [4:0] OP_MULHSU = 5'd12;
   localparam logic [4:0] OP_MULHU  = 5'd13;
   localparam logic [4:0] OP_DIV    = 5'd14;
   localparam logic [4:0] OP_DIVU   = 5'd15;
   localparam logic [4:0] OP_REM    = 5'd16;
   localparam logic [4:0] OP_REMU   = 5'd17;

   localparam int SHW = $clog2(XLEN);
   localparam int CW  = $clog2(XLEN + 1);
   localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
   logic [4:0]        op_q, op_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [XLEN-1:0]   rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
   logic [XLEN-1:0]   alu_out_q, alu_out_d;
   logic              eq_q, eq_d, gt_q, gt_d, gtu_q, gtu_d;
   logic              out_valid_q, out_valid_d, busy_q, busy_d;

   // In IDLE the live inputs are the operands being accepted; afterwards the
   // latched copies feed the same datapath.
   logic              is_idle;
   logic [XLEN-1:0]   op_a, op_b;
   logic [4:0]        op_sel;
   logic              eq_c, gt_c, gtu_c, lt_c, ltu_c;
   logic [SHW-1:0]    shamt;
   logic [2*XLEN-1:0] ext_a, ext_b, prod;
   logic              is_mul, is_div, sgn_div, b_zero, ovf, div_special;
   logic [XLEN-1:0]   special_res, alu_c, mag_a, mag_b;
   logic [XLEN:0]     rem_sh;
   logic [XLEN-1:0]   rem_n, quo_n, quo_fix, rem_fix, div_res;
   logic              load_res;
   logic [XLEN-1:0]   res_sel;

   assign is_idle = (state_q == S_IDLE);
   assign op_a    = is_idle ? A     : a_q;
   assign op_b    = is_idle ? B     : b_q;
   assign op_sel  = is_idle ? ALUOp : op_q;

   assign eq_c  = (op_a == op_b);
   assign gt_c  = ($signed(op_a) > $signed(op_b));
   assign gtu_c = (op_a > op_b);
   assign lt_c  = ($signed(op_a) < $signed(op_b));
   assign ltu_c = (op_a < op_b);
   assign shamt = op_b[SHW-1:0];

   assign is_mul  = (op_sel == OP_MUL) || (op_sel == OP_MULH) ||
                    (op_sel == OP_MULHSU) || (op_sel == OP_MULHU);
   assign is_div  = (op_sel == OP_DIV) || (op_sel == OP_DIVU) ||
                    (op_sel == OP_REM) || (op_sel == OP_REMU);
   assign sgn_div = (op_sel == OP_DIV) || (op_sel == OP_REM);

   // One 2*XLEN multiplier covers all four variants: the low 2*XLEN bits of
   // the product of the extended operands are exact for every signedness mix.
   assign ext_a = ((op_sel == OP_MULH) || (op_sel == OP_MULHSU)) ?
                  {{XLEN{op_a[XLEN-1]}}, op_a} : {{XLEN{1'b0}}, op_a};
   assign ext_b = (op_sel == OP_MULH) ?
                  {{XLEN{op_b[XLEN-1]}}, op_b} : {{XLEN{1'b0}}, op_b};
   assign prod  = ext_a * ext_b;

   assign b_zero      = (op_b == '0);
   assign ovf         = sgn_div && (op_a == MIN_INT) && (op_b == '1);
   assign div_special = is_div && (b_zero || ovf);

   always_comb begin
      special_res = '0;
      if (b_zero)
         special_res = ((op_sel == OP_DIV) || (op_sel == OP_DIVU)) ? '1 : op_a;
      else if (ovf)
         special_res = (op_sel == OP_DIV) ? MIN_INT : '0;
   end

   always_comb begin
      alu_c = '0;
      case (op_sel)
         OP_ADD:    alu_c = op_a + op_b;
         OP_SUB:    alu_c = op_a - op_b;
         OP_SLT:    alu_c = {{(XLEN-1){1'b0}}, lt_c};
         OP_SLTU:   alu_c = {{(XLEN-1){1'b0}}, ltu_c};
         OP_AND:    alu_c = op_a & op_b;
         OP_OR:     alu_c = op_a | op_b;
         OP_XOR:    alu_c = op_a ^ op_b;
         OP_SLL:    alu_c = op_a << shamt;
         OP_SRL:    alu_c = op_a >> shamt;
         OP_SRA:    alu_c = $signed(op_a) >>> shamt;
         OP_MUL:    alu_c = prod[XLEN-1:0];
         OP_MULH,
         OP_MULHSU,
         OP_MULHU:  alu_c = prod[2*XLEN-1:XLEN];
         OP_DIV,
         OP_DIVU,
         OP_REM,
         OP_REMU:   alu_c = special_res;
         default:   alu_c = '0;
      endcase
   end

   assign mag_a = (sgn_div && op_a[XLEN-1]) ? -op_a : op_a;
   assign mag_b = (sgn_div && op_b[XLEN-1]) ? -op_b : op_b;

   // Restoring step: shift the next dividend bit into the partial remainder
   // and subtract the divisor when it fits.
   assign rem_sh = {rem_q, quo_q[XLEN-1]};
   always_comb begin
      if (rem_sh >= {1'b0, dvs_q}) begin
         rem_n = rem_sh[XLEN-1:0] - dvs_q;
         quo_n = {quo_q[XLEN-2:0], 1'b1};
      end else begin
         rem_n = rem_sh[XLEN-1:0];
         quo_n = {quo_q[XLEN-2:0], 1'b0};
      end
   end

   assign quo_fix = (sgn_div && (a_q[XLEN-1] ^ b_q[XLEN-1])) ? -quo_n : quo_n;
   assign rem_fix = (sgn_div && a_q[XLEN-1]) ? -rem_n : rem_n;
   assign div_res = ((op_q == OP_DIV) || (op_q == OP_DIVU)) ? quo_fix : rem_fix;

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      op_d      = op_q;
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      dvs_d     = dvs_q;
      alu_out_d = alu_out_q;
      eq_d      = eq_q;
      gt_d      = gt_q;
      gtu_d     = gtu_q;
      load_res  = 1'b0;
      res_sel   = alu_c;

      if (flush) begin
         state_d = S_IDLE;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  a_d  = A;
                  b_d  = B;
                  op_d = ALUOp;
                  if (is_mul) begin
                     if (MUL_CYCLES == 1) begin
                        state_d  = S_DONE;
                        load_res = 1'b1;
                     end else begin
                        state_d = S_MUL;
                        cnt_d   = CW'(MUL_CYCLES - 1);
                     end
                  end else if (is_div && !div_special) begin
                     state_d = S_DIV;
                     cnt_d   = CW'(XLEN);
                     rem_d   = '0;
                     quo_d   = mag_a;
                     dvs_d   = mag_b;
                  end else begin
                     state_d  = S_DONE;
                     load_res = 1'b1;
                  end
               end
            end
            S_MUL: begin
               cnt_d = cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  state_d  = S_DONE;
                  load_res = 1'b1;
               end
            end
            S_DIV: begin
               rem_d = rem_n;
               quo_d = quo_n;
               cnt_d = cnt_q - CW'(1);
               // Last iteration: sign-correct the fresh quotient/remainder.
               if (cnt_q == CW'(1)) begin
                  state_d  = S_DONE;
                  load_res = 1'b1;
                  res_sel  = div_res;
               end
            end
            S_DONE: begin
               if (out_ready)
                  state_d = S_IDLE;
            end
         endcase
      end

      if (load_res) begin
         alu_out_d = res_sel;
         eq_d      = eq_c;
         gt_d      = gt_c;
         gtu_d     = gtu_c;
      end

      out_valid_d = (state_d == S_DONE);
      busy_d      = (state_d == S_MUL) || (state_d == S_DIV);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         op_q        <= '0;
         cnt_q       <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         dvs_q       <= '0;
         alu_out_q   <= '0;
         eq_q        <= 1'b0;
         gt_q        <= 1'b0;
         gtu_q       <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         op_q        <= op_d;
         cnt_q       <= cnt_d;
         rem_q       <= rem_d;
         quo_q       <= quo_d;
         dvs_q       <= dvs_d;
         alu_out_q   <= alu_out_d;
         eq_q        <= eq_d;
         gt_q        <= gt_d;
         gtu_q       <= gtu_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   // Held low while rst is asserted so nothing is accepted during reset.
   assign in_ready  = is_idle & ~rst;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign ALUOut    = alu_out_q;
   assign Eq        = eq_q;
   assign Gt        = gt_q;
   assign GtU       = gtu_q;

endmodule

// File: tb/tb_alu_mdu_seq.sv
module tb_alu_mdu_seq;

   localparam int XLEN       = 32;
   localparam int MUL_CYCLES = 2;

   localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_SLT = 5'd2,  OP_SLTU = 5'd3;
   localparam logic [4:0] OP_AND = 5'd4,  OP_OR  = 5'd5,  OP_XOR = 5'd6,  OP_SLL  = 5'd7;
   localparam logic [4:0] OP_SRL = 5'd8,  OP_SRA = 5'd9,  OP_MUL = 5'd10, OP_MULH = 5'd11;
   localparam logic [4:0] OP_MULHSU = 5'd12, OP_MULHU = 5'd13, OP_DIV = 5'd14;
   localparam logic [4:0] OP_DIVU = 5'd15, OP_REM = 5'd16, OP_REMU = 5'd17;
   localparam logic [31:0] MIN_INT = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] A, B, ALUOut;
   logic [4:0]  ALUOp;
   logic        Eq, Gt, GtU, busy;

   int checks = 0;
   int errors = 0;

   alu_mdu_seq #(.XLEN(XLEN), .MUL_CYCLES(MUL_CYCLES)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .ALUOp(ALUOp),
      .out_valid(out_valid), .out_ready(out_ready),
      .ALUOut(ALUOut), .Eq(Eq), .Gt(Gt), .GtU(GtU), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: plain 64-bit integer arithmetic on the operands.
   function automatic logic [31:0] ref_res(input logic [4:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      longint          sa, sb;
      longint unsigned ua, ub;
      logic [63:0]     p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      p  = '0;
      case (op)
         OP_ADD:    return a + b;
         OP_SUB:    return a - b;
         OP_SLT:    return 32'(sa < sb);
         OP_SLTU:   return 32'(ua < ub);
         OP_AND:    return a & b;
         OP_OR:     return a | b;
         OP_XOR:    return a ^ b;
         OP_SLL:    return a << b[4:0];
         OP_SRL:    return a >> b[4:0];
         OP_SRA:    begin p = sa >>> b[4:0]; return p[31:0]; end
         OP_MUL:    begin p = sa * sb; return p[31:0]; end
         OP_MULH:   begin p = sa * sb; return p[63:32]; end
         OP_MULHSU: begin p = sa * longint'(ub); return p[63:32]; end
         OP_MULHU:  begin p = ua * ub; return p[63:32]; end
         OP_DIV: begin
            if (b == 0) return '1;
            if (a == MIN_INT && b == '1) return MIN_INT;
            p = sa / sb; return p[31:0];
         end
         OP_REM: begin
            if (b == 0) return a;
            if (a == MIN_INT && b == '1) return 32'd0;
            p = sa % sb; return p[31:0];
         end
         OP_DIVU:   begin if (b == 0) return '1; p = ua / ub; return p[31:0]; end
         OP_REMU:   begin if (b == 0) return a;  p = ua % ub; return p[31:0]; end
         default:   return 32'd0;
      endcase
   endfunction

   function automatic int ref_lat(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      if (op >= OP_MUL && op <= OP_MULHU) return MUL_CYCLES;
      if (op >= OP_DIV && op <= OP_REMU) begin
         if (b == 0) return 1;
         if ((op == OP_DIV || op == OP_REM) && a == MIN_INT && b == '1) return 1;
         return XLEN + 1;
      end
      return 1;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'd0;
         1: return 32'd1;
         2: return 32'hFFFF_FFFF;
         3: return MIN_INT;
         4: return 32'($urandom_range(0, 40));
         default: return $urandom;
      endcase
   endfunction

   // Issue one op, measure latency (cycles after the accept cycle), check the
   // result and flags, optionally hold backpressure, then retire it.
   task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold, output logic [31:0] res);
      logic [31:0] exp_r;
      int          k;
      exp_r = ref_res(op, a, b);
      @(negedge clk);
      chk("in_ready_pre", in_ready, 1);
      in_valid = 1; A = a; B = b; ALUOp = op; out_ready = 0;
      @(posedge clk); #1;
      in_valid = 0; A = $urandom; B = $urandom; ALUOp = 5'($urandom);
      k = 1;
      while (!out_valid && k < 100) begin
         @(posedge clk); #1;
         k++;
      end
      chk("latency", k, ref_lat(op, a, b));
      chk("result", ALUOut, exp_r);
      chk("flags", {Eq, Gt, GtU}, {a == b, $signed(a) > $signed(b), a > b});
      res = ALUOut;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk("hold", {out_valid, in_ready, ALUOut}, {2'b10, exp_r});
      end
      out_ready = 1;
      @(posedge clk); #1;
      out_ready = 0;
      chk("retire", {out_valid, in_ready}, 2'b01);
   endtask

   logic [31:0] r;
   logic        seen;

   initial begin
      rst = 1; flush = 0; in_valid = 0; out_ready = 0; A = '0; B = '0; ALUOp = '0;
      #1;
      chk("reset_outs", {ALUOut, Eq, Gt, GtU, out_valid, busy}, '0);
      @(negedge clk); @(negedge clk);
      rst = 0;
      #1;
      chk("reset_in_ready", in_ready, 1);

      do_op(OP_ADD,  32'hFFFF_FFFF, 32'd1, 0, r); chk("kat_add", r, 32'd0);
      do_op(OP_SLL,  32'd1, 32'h21, 0, r);        chk("kat_sll", r, 32'd2);
      do_op(OP_SRA,  MIN_INT, 32'd31, 0, r);      chk("kat_sra", r, 32'hFFFF_FFFF);
      do_op(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, r); chk("kat_mulhu", r, 32'hFFFF_FFFE);
      do_op(OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, r);  chk("kat_mulh", r, 32'd0);
      do_op(OP_DIV,  -32'sd7, 32'd2, 0, r);       chk("kat_div", r, 32'hFFFF_FFFD);
      do_op(OP_REM,  -32'sd7, 32'd2, 0, r);       chk("kat_rem", r, 32'hFFFF_FFFF);
      do_op(OP_DIVU, 32'd100, 32'd7, 0, r);       chk("kat_divu", r, 32'd14);
      do_op(OP_REMU, 32'd100, 32'd7, 0, r);       chk("kat_remu", r, 32'd2);
      do_op(OP_DIV,  32'd5, 32'd0, 0, r);         chk("kat_div0", r, 32'hFFFF_FFFF);
      do_op(OP_REM,  MIN_INT, 32'hFFFF_FFFF, 0, r); chk("kat_rem_ovf", r, 32'd0);
      do_op(OP_DIV,  MIN_INT, 32'hFFFF_FFFF, 0, r); chk("kat_div_ovf", r, MIN_INT);
      do_op(OP_XOR,  32'h1234_5678, 32'h0F0F_0F0F, 5, r);
      do_op(5'd25,   32'd3, 32'd3, 0, r);         chk("kat_unknown", r, 32'd0);

      // New request alongside retire: not accepted until the next IDLE cycle.
      @(negedge clk);
      in_valid = 1; A = 32'd9; B = 32'd4; ALUOp = OP_ADD;
      @(posedge clk); #1;
      chk("bubble_first", {out_valid, ALUOut}, {1'b1, 32'd13});
      @(negedge clk);
      A = 32'd9; B = 32'd4; ALUOp = OP_SUB; out_ready = 1;
      @(posedge clk); #1;
      out_ready = 0;
      chk("bubble_retire", {out_valid, in_ready}, 2'b01);
      @(posedge clk); #1;
      in_valid = 0;
      chk("bubble_second", {out_valid, ALUOut}, {1'b1, 32'd5});
      out_ready = 1;
      @(posedge clk); #1;
      out_ready = 0;

      // Flush at DIV iteration 10.
      @(negedge clk);
      in_valid = 1; A = 32'd1000; B = 32'd3; ALUOp = OP_DIVU;
      @(posedge clk); #1;
      in_valid = 0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      chk("div_busy", busy, 1);
      flush = 1;
      @(posedge clk); #1;
      flush = 0;
      chk("flush_div", {out_valid, in_ready, busy}, 3'b010);
      seen = 0;
      repeat (40) begin @(posedge clk); #1; seen |= out_valid; end
      chk("flush_no_result", seen, 0);

      // Flush drops a held result and wins over a same-cycle accept.
      @(negedge clk);
      in_valid = 1; A = 32'd2; B = 32'd2; ALUOp = OP_ADD;
      @(posedge clk); #1;
      in_valid = 0;
      chk("held_valid", out_valid, 1);
      @(negedge clk);
      flush = 1; out_ready = 1;
      @(posedge clk); #1;
      chk("flush_done", {out_valid, in_ready}, 2'b01);
      @(negedge clk);
      in_valid = 1; out_ready = 0;
      @(posedge clk); #1;
      flush = 0; in_valid = 0;
      chk("flush_over_accept", {out_valid, busy, in_ready}, 3'b001);

      // Async reset mid-MUL.
      do_op(OP_ADD, 32'd5, 32'd5, 0, r);
      @(negedge clk);
      in_valid = 1; A = 32'd7; B = 32'd6; ALUOp = OP_MUL;
      @(posedge clk); #1;
      in_valid = 0;
      chk("mul_busy", {busy, ALUOut}, {1'b1, 32'd10});
      #2 rst = 1;
      #1;
      chk("async_rst", {ALUOut, Eq, Gt, GtU, out_valid, busy}, '0);
      @(negedge clk);
      rst = 0;
      seen = 0;
      repeat (4) begin @(posedge clk); #1; seen |= out_valid; end
      chk("rst_no_result", {seen, in_ready}, 2'b01);

      for (int i = 0; i < 60; i++) begin
         do_op(5'($urandom_range(0, 19)), pick(), pick(), $urandom_range(0, 2), r);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
